layer_compositor: RTL and testbench
===================================

# layer_compositor

Parametrised N-layer pixel compositor sitting between the per-object drawing units and the VGA output stage. It selects, per pixel, the highest-priority active layer's RGB332 colour over a background, expands it to 24-bit RGB, and drives the VGA output stage. Unlike a fixed priority mux, it supports:
- per-layer enable masking,
- frame-synchronous per-layer blinking,
- colour-key transparency,
- a reported winning-layer index,
- a per-frame overlap (collision) report that game logic reads once per frame.

## Interface
Parameters:
- N_LAYERS, 13, number of object layers; layer 0 = highest priority, N_LAYERS-1 = lowest above background; legal 2..32
- BLINK_HALF_FRAMES, 8, frames per blink half-period; legal 1..255
- TRANSPARENT_EN, 1, when 1 a layer pixel equal to TRANSPARENT_KEY is treated as not drawing
- TRANSPARENT_KEY, 8'hFF, RGB332 colour key
- IDXW, $clog2(N_LAYERS+1), width of winner index

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- layerRGB  in  8*N_LAYERS  packed RGB332, layer i at [8i+7:8i]
- layerDrawingRequest  in  N_LAYERS  per-layer draw request for the current pixel
- layerEnable  in  N_LAYERS  static-ish mask; 0 suppresses layer
- layerBlink  in  N_LAYERS  1 = layer participates in blinking
- backGroundRGB  in  8  RGB332 background, last priority
- startOfFrame  in  1  single-cycle pulse at first pixel of each frame
- redOut / greenOut / blueOut  out  8 each  expanded colour
- winnerLayer  out  IDXW  index of the displayed layer; N_LAYERS = background
- collisionFlags  out  N_LAYERS  bit i = layer i overlapped another qualified layer in the last completed frame
- collisionValid  out  1  one-cycle pulse when collisionFlags updates

## Operation
- **Qualification (combinational, input cycle).** q[i] = layerDrawingRequest[i] & layerEnable[i] & !(layerBlink[i] & blinkOff) & !(TRANSPARENT_EN & layerRGB[i]==TRANSPARENT_KEY).
- **Stage 1 (registered).** Captures q vector, layerRGB and backGroundRGB.
- **Stage 2 (registered).**
  - Priority select: the lowest index i with q[i]=1 gives tmpRGB = layerRGB[i], winnerLayer = i.
  - If none qualify: tmpRGB = background, winnerLayer = N_LAYERS.
- **Expansion (combinational from stage-2 register).**
  - red = {tmp[7:5], 5×tmp[5]}
  - green = {tmp[4:2], 5×tmp[2]}
  - blue = {tmp[1:0], 6×tmp[0]}
- **Blink.**
  - 8-bit frameCnt increments on each startOfFrame and wraps from BLINK_HALF_FRAMES-1 to 0.
  - Each wrap toggles blinkOff.
  - The new blinkOff applies from the cycle after the startOfFrame edge.
- **Collision.**
  - overlap = (popcount(q) >= 2).
  - On each non-startOfFrame cycle: accum <= accum | (overlap ? q : 0).
  - On a startOfFrame cycle:
    - collisionFlags <= accum; collisionValid <= 1.
    - accum <= (overlap ? q : 0), i.e. the startOfFrame pixel belongs to the new frame.
  - collisionValid is 0 on all other cycles.
  - The report uses the qualified vector, so disabled, blinked-off and transparent layers never collide.
- The collision report is valid only after the first full frame; the first collisionValid after reset reports a partial frame.

## Timing
- Pixel-to-colour latency is 2 cycles: inputs sampled at edge k appear on RGB/winnerLayer after edge k+1.
- collisionFlags/collisionValid update at the startOfFrame edge itself (latency 1).
- Throughput is 1 pixel/clock with no stalls and no handshake.
- Reset (asynchronous, resetN=0) drives every output and state element immediately:
  - tmpRGB=0, so RGB outputs = 0
  - winnerLayer = N_LAYERS
  - collisionFlags = 0, collisionValid = 0
  - accum = 0, frameCnt = 0, blinkOff = 0
  - pipeline registers cleared
- Reset deassertion mid-frame: counting restarts from frameCnt=0 at the next startOfFrame, and accum accumulates from the first post-reset cycle.
- Simultaneous events:
  - All requests active: layer 0 wins.
  - startOfFrame with an overlapping pixel: that pixel goes into the new accum, not the reported flags.
  - startOfFrame on a wrap cycle: toggle and report occur in the same edge.
- BLINK_HALF_FRAMES=1 toggles blinkOff on every frame.

## Test plan
- **Priority.** N=4; layers 1 and 3 request, RGB 8'hE0 and 8'h1C, others off → after 2 cycles winnerLayer=1, red=8'hFF, green=0, blue=0; then drop all requests with background 8'h03 → winnerLayer=4, blue=8'hFF.
- **Transparency and enable.** Layer 0 RGB=8'hFF requesting, layer 2 RGB=8'h1C requesting → winnerLayer=2, green=8'hFF; then clear layerEnable[2] → winnerLayer=4, output = background.
- **Blink.** BLINK_HALF_FRAMES=2, layer 0 blink-enabled, constant request:
  - frames 0–1 show layer 0
  - frames 2–3 show background
  - frame 4 shows layer 0 again
  - the change is visible 2 cycles after the relevant startOfFrame.
- **Collision.** Frame A: layers 0 and 2 overlap for 3 pixels, layer 1 alone → next startOfFrame gives collisionValid=1 for exactly one cycle, collisionFlags=4'b0101. Frame B has no overlap → following report is 4'b0000.
- **Boundary.** Overlap of layers 1 and 3 exactly on the startOfFrame cycle → current report excludes bits 1 and 3; the next report includes them.
- **Reset mid-frame.** Assert resetN=0 mid-frame with non-zero outputs → all outputs drop to reset values without a clock edge. Release resetN → the first pixel output appears 2 cycles later with correct priority.

Source files
------------

// File: rtl/layer_compositor.sv
// N-layer RGB332 priority compositor with enable mask, frame-synchronous blink,
// colour-key transparency, winner index and a per-frame collision report.
module layer_compositor #(
    parameter int unsigned N_LAYERS          = 13,
    parameter int unsigned BLINK_HALF_FRAMES = 8,
    parameter int unsigned TRANSPARENT_EN    = 1,
    parameter logic [7:0]  TRANSPARENT_KEY   = 8'hFF,
    parameter int unsigned IDXW              = $clog2(N_LAYERS + 1)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [8*N_LAYERS-1:0] layerRGB,
    input  logic [N_LAYERS-1:0]   layerDrawingRequest,
    input  logic [N_LAYERS-1:0]   layerEnable,
    input  logic [N_LAYERS-1:0]   layerBlink,
    input  logic [7:0]            backGroundRGB,
    input  logic                  startOfFrame,
    output logic [7:0]            redOut,
    output logic [7:0]            greenOut,
    output logic [7:0]            blueOut,
    output logic [IDXW-1:0]       winnerLayer,
    output logic [N_LAYERS-1:0]   collisionFlags,
    output logic                  collisionValid
);
    localparam logic [IDXW-1:0]     BG_IDX   = IDXW'(N_LAYERS);
    localparam logic [7:0]          LAST_CNT = 8'(BLINK_HALF_FRAMES - 1);
    localparam logic [N_LAYERS-1:0] ONE      = 1;

    logic                  blink_off;
    logic [7:0]            frame_cnt;
    logic [N_LAYERS-1:0]   q;
    logic [N_LAYERS-1:0]   hits;
    logic [N_LAYERS-1:0]   accum;
    logic [N_LAYERS-1:0]   q_s1;
    logic [8*N_LAYERS-1:0] rgb_s1;
    logic [7:0]            bg_s1;
    logic [7:0]            sel_rgb;
    logic [IDXW-1:0]       sel_idx;
    logic                  sel_found;
    logic [7:0]            tmp_rgb;

    always_comb begin
        q = '0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            q[i] = layerDrawingRequest[i] & layerEnable[i] & !(layerBlink[i] & blink_off)
                 & !((TRANSPARENT_EN != 0) && (layerRGB[8*i +: 8] == TRANSPARENT_KEY));
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    assign hits = ((q & (q - ONE)) != '0) ? q : '0;

    always_comb begin
        sel_rgb   = bg_s1;
        sel_idx   = BG_IDX;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (q_s1[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_rgb   = rgb_s1[8*i +: 8];
                sel_idx   = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            q_s1        <= '0;
            rgb_s1      <= '0;
            bg_s1       <= '0;
            tmp_rgb     <= '0;
            winnerLayer <= BG_IDX;
        end else begin
            q_s1        <= q;
            rgb_s1      <= layerRGB;
            bg_s1       <= backGroundRGB;
            tmp_rgb     <= sel_rgb;
            winnerLayer <= sel_idx;
        end
    end

    // The startOfFrame pixel opens the new frame: it seeds accum instead of joining the report.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt      <= '0;
            blink_off      <= 1'b0;
            accum          <= '0;
            collisionFlags <= '0;
            collisionValid <= 1'b0;
        end else begin
            collisionValid <= startOfFrame;
            if (startOfFrame) begin
                collisionFlags <= accum;
                accum          <= hits;
                if (frame_cnt == LAST_CNT) begin
                    frame_cnt <= '0;
                    blink_off <= !blink_off;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end else begin
                accum <= accum | hits;
            end
        end
    end

    assign redOut   = {tmp_rgb[7:5], {5{tmp_rgb[5]}}};
    assign greenOut = {tmp_rgb[4:2], {5{tmp_rgb[2]}}};
    assign blueOut  = {tmp_rgb[1:0], {6{tmp_rgb[0]}}};

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a driver feeds pixels and queues expected
// results from a frame-level reference model; a monitor pops and compares.
module tb_layer_compositor;
    localparam int N  = 4;
    localparam int H  = 2;
    localparam int IW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           resetN;
    logic [8*N-1:0] layerRGB;
    logic [N-1:0]   layerDrawingRequest;
    logic [N-1:0]   layerEnable;
    logic [N-1:0]   layerBlink;
    logic [7:0]     backGroundRGB;
    logic           startOfFrame;
    logic [7:0]     redOut, greenOut, blueOut;
    logic [IW-1:0]  winnerLayer;
    logic [N-1:0]   collisionFlags;
    logic           collisionValid;

    layer_compositor #(
        .N_LAYERS(N),
        .BLINK_HALF_FRAMES(H),
        .TRANSPARENT_EN(1),
        .TRANSPARENT_KEY(8'hFF)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .layerRGB(layerRGB),
        .layerDrawingRequest(layerDrawingRequest),
        .layerEnable(layerEnable),
        .layerBlink(layerBlink),
        .backGroundRGB(backGroundRGB),
        .startOfFrame(startOfFrame),
        .redOut(redOut),
        .greenOut(greenOut),
        .blueOut(blueOut),
        .winnerLayer(winnerLayer),
        .collisionFlags(collisionFlags),
        .collisionValid(collisionValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        logic [7:0]    r, g, b;
        logic [IW-1:0] w;
    } pix_t;

    typedef struct {
        int unsigned due;
        logic [N-1:0] f;
    } col_t;

    pix_t pq[$];
    col_t cq[$];
    pix_t mon_p;
    col_t mon_c;
    logic mon_exp_v;

    int unsigned edges = 0;
    int checks = 0;
    int passes = 0;

    // Reference model state: frames seen since reset and overlaps of the open frame.
    int sof_count = 0;
    logic [N-1:0] accum = '0;

    logic [8*N-1:0] s_rgb;
    logic [N-1:0]   s_req, s_en, s_blk;
    logic [7:0]     s_bg;

    task automatic step(input logic s);
        logic [N-1:0] q;
        logic         boff;
        logic [7:0]   c;
        logic [7:0]   tmp;
        int           w;
        pix_t         p;
        col_t         cr;
        @(negedge clk);
        layerRGB            = s_rgb;
        layerDrawingRequest = s_req;
        layerEnable         = s_en;
        layerBlink          = s_blk;
        backGroundRGB       = s_bg;
        startOfFrame        = s;
        boff = ((sof_count / H) % 2) == 1;
        for (int i = 0; i < N; i++) begin
            c    = s_rgb[8*i +: 8];
            q[i] = s_req[i] && s_en[i] && !(s_blk[i] && boff) && (c != 8'hFF);
        end
        w   = N;
        tmp = s_bg;
        for (int i = N - 1; i >= 0; i--) begin
            if (q[i]) begin
                w   = i;
                tmp = s_rgb[8*i +: 8];
            end
        end
        p.due = edges + 2;
        p.r   = {tmp[7:5], {5{tmp[5]}}};
        p.g   = {tmp[4:2], {5{tmp[2]}}};
        p.b   = {tmp[1:0], {6{tmp[0]}}};
        p.w   = IW'(w);
        pq.push_back(p);
        if (s) begin
            cr.due = edges + 1;
            cr.f   = accum;
            cq.push_back(cr);
            accum = ($countones(q) >= 2) ? q : '0;
            sof_count++;
        end else if ($countones(q) >= 2) begin
            accum = accum | q;
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (redOut == 8'h00 && greenOut == 8'h00 && blueOut == 8'h00) passes++;
        else $display("FAIL %s_rgb: got %h/%h/%h want 00/00/00", name, redOut, greenOut, blueOut);
        checks++;
        if (winnerLayer == IW'(N)) passes++;
        else $display("FAIL %s_winner: got %0d want %0d", name, winnerLayer, N);
        checks++;
        if (collisionFlags == '0 && collisionValid == 1'b0) passes++;
        else $display("FAIL %s_collision: got flags=%b valid=%b want 0000/0", name, collisionFlags, collisionValid);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        s_req               = '0;
        layerDrawingRequest = '0;
        startOfFrame        = 1'b0;
        #2 resetN = 1'b0;
        #1 check_reset("reset_mid");
        pq.delete();
        cq.delete();
        accum     = '0;
        sof_count = 0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        edges++;
        if (resetN) begin
            if (pq.size() > 0 && pq[0].due <= edges) begin
                mon_p = pq.pop_front();
                checks++;
                if (mon_p.due == edges && redOut == mon_p.r && greenOut == mon_p.g &&
                    blueOut == mon_p.b && winnerLayer == mon_p.w)
                    passes++;
                else
                    $display("FAIL pixel@%0d: got rgb=%h%h%h win=%0d want rgb=%h%h%h win=%0d",
                             edges, redOut, greenOut, blueOut, winnerLayer,
                             mon_p.r, mon_p.g, mon_p.b, mon_p.w);
            end
            mon_exp_v = (cq.size() > 0 && cq[0].due <= edges);
            if (mon_exp_v || collisionValid) begin
                checks++;
                if (mon_exp_v) mon_c = cq.pop_front();
                if (mon_exp_v && mon_c.due == edges && collisionValid && collisionFlags == mon_c.f)
                    passes++;
                else
                    $display("FAIL collision@%0d: got valid=%b flags=%b want valid=%b flags=%b",
                             edges, collisionValid, collisionFlags, mon_exp_v, mon_c.f);
            end
        end
    end

    int frame_pos;

    initial begin
        resetN = 1'b1;
        s_rgb = '0; s_req = '0; s_en = '1; s_blk = '0; s_bg = '0;
        layerRGB = '0; layerDrawingRequest = '0; layerEnable = '1; layerBlink = '0;
        backGroundRGB = '0; startOfFrame = 1'b0;
        mon_c = '{due: 0, f: '0};
        #1 resetN = 1'b0;
        #2 check_reset("reset_init");
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Priority: layers 1 and 3 request, layer 1 wins; then background only.
        s_rgb = {8'h1C, 8'h00, 8'hE0, 8'h00};
        s_req = 4'b1010; s_bg = 8'h03;
        repeat (3) step(1'b0);
        s_req = 4'b0000;
        repeat (3) step(1'b0);

        // Transparency on layer 0, then enable mask on layer 2.
        s_rgb = {8'h00, 8'h1C, 8'h00, 8'hFF};
        s_req = 4'b0101;
        repeat (3) step(1'b0);
        s_en = 4'b1011;
        repeat (3) step(1'b0);
        s_en = 4'b1111;

        // Blink: layer 0 alone, five frames of six pixels.
        s_rgb = {8'h00, 8'h00, 8'h00, 8'hE0};
        s_req = 4'b0001; s_blk = 4'b0001; s_bg = 8'h4A;
        for (int f = 0; f < 5; f++) begin
            step(1'b1);
            repeat (5) step(1'b0);
        end
        s_blk = '0;

        // Collision: frame A overlaps 0 and 2, frame B clean, then boundary on 1 and 3.
        s_rgb = {8'h1C, 8'h1C, 8'hE0, 8'hE0};
        s_req = 4'b0000; step(1'b1);
        s_req = 4'b0101; repeat (3) step(1'b0);
        s_req = 4'b0010; repeat (2) step(1'b0);
        s_req = 4'b0000; step(1'b1);
        s_req = 4'b0001; repeat (3) step(1'b0);
        s_req = 4'b1010; step(1'b1);
        s_req = 4'b0100; repeat (3) step(1'b0);
        s_req = 4'b0000; step(1'b1);
        repeat (2) step(1'b0);

        // Randomised traffic with a reset dropped in mid-frame.
        frame_pos = 0;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                mid_reset();
                s_rgb = {8'h1C, 8'h55, 8'hE0, 8'h00};
                s_req = 4'b1010; s_en = '1; s_blk = '0; s_bg = 8'h03;
                repeat (3) step(1'b0);
                frame_pos = 1;
            end
            for (int i = 0; i < N; i++) begin
                s_rgb[8*i +: 8] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
                s_en[i]         = ($urandom_range(0, 7) != 0);
            end
            s_req = N'($urandom);
            s_blk = N'($urandom);
            s_bg  = 8'($urandom);
            step(frame_pos == 0);
            frame_pos = (frame_pos + 1) % (7 + int'($urandom_range(0, 4)));
        end

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (pq.size() == 0 && cq.size() == 0) passes++;
        else $display("FAIL drain: got %0d pixels and %0d reports outstanding want 0/0", pq.size(), cq.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
